and3_triple_tester: RTL and testbench

- Sequencer that exhaustively exercises a triple 3-input AND gate device (three independent AND3 gates, 9 inputs, 3 outputs).
- Drives all 512 input combinations, waits a programmable settle time per vector, samples the device outputs and compares them against the expected AND results.
- Reports pass/fail, an error count and the first failing vector.
- Sits beside the gate device on the lab bench top level: its outputs feed the gate inputs, and the gate outputs return to it.

---
 rtl/and3_triple_tester.sv | 144 ++++++++++++++
 tb/tb_and3_triple_tester.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/and3_triple_tester.sv
// Exhaustive sequencer for a triple 3-input AND device: drives all 512 input
// vectors, samples the device outputs after a settle time and records errors.
module and3_triple_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_start,
  input  logic                 in_abort,
  input  logic [2:0]           in_y,
  output logic [8:0]           out_drive,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_pass,
  output logic [ERR_CNT_W-1:0] out_err_cnt,
  output logic                 out_fail_valid,
  output logic [8:0]           out_fail_vec,
  output logic [2:0]           out_fail_y
);

  // state  | meaning
  // IDLE   | waiting for start, outputs quiet
  // SETTLE | vector driven, counting settle cycles
  // CHECK  | sample in_y and compare against the AND of the vector
  // DONE   | run complete, results held until next start
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [8:0] VEC_LAST    = 9'd511;

  state_e                state_q, state_d;
  logic [8:0]            vec_q, vec_d;
  logic [8:0]            drive_q, drive_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic                  fail_valid_q, fail_valid_d;
  logic [8:0]            fail_vec_q, fail_vec_d;
  logic [2:0]            fail_y_q, fail_y_d;

  logic                  busy;
  logic                  start_take;
  logic                  abort_take;
  logic [2:0]            exp_y;

  assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign start_take = in_start && !busy;
  assign abort_take = in_abort && busy;
  assign exp_y      = {&vec_q[8:6], &vec_q[5:3], &vec_q[2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      drive_q      <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      drive_q      <= drive_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_y_q     <= fail_y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (in_abort)                  state_d = S_IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (in_abort)               state_d = S_IDLE;
        else if (vec_q == VEC_LAST) state_d = S_DONE;
        else                        state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; abort takes priority over a CHECK in the same cycle
  // so an aborted vector is never scored.
  always_comb begin
    vec_d        = vec_q;
    drive_d      = drive_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_y_d     = fail_y_q;
    if (start_take) begin
      vec_d        = '0;
      drive_d      = '0;
      cnt_d        = '0;
      err_d        = '0;
      fail_valid_d = 1'b0;
      fail_vec_d   = '0;
      fail_y_d     = '0;
    end else if (abort_take) begin
      vec_d   = '0;
      drive_d = '0;
      cnt_d   = '0;
    end else if (state_q == S_SETTLE) begin
      cnt_d = cnt_q + 8'd1;
    end else if (state_q == S_CHECK) begin
      if (in_y != exp_y) begin
        if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + 1'b1;
        if (!fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_vec_d   = vec_q;
          fail_y_d     = in_y;
        end
      end
      if (vec_q != VEC_LAST) begin
        vec_d   = vec_q + 9'd1;
        drive_d = vec_q + 9'd1;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    out_drive      = drive_q;
    out_busy       = busy;
    out_done       = (state_q == S_DONE);
    out_pass       = (state_q == S_DONE) && (err_q == '0);
    out_err_cnt    = err_q;
    out_fail_valid = fail_valid_q;
    out_fail_vec   = fail_vec_q;
    out_fail_y     = fail_y_q;
  end

endmodule

// File: tb/tb_and3_triple_tester.sv
// Bench for and3_triple_tester: a faultable AND3 device model closes the loop,
// and a whole-run reference model predicts error count and first failure.
module tb_and3_triple_tester;

  localparam int RUN_CYCLES = 512 * (2 + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic        in_abort = 1'b0;
  logic [2:0]  y_a, y_b;
  logic [8:0]  drive_a, drive_b;
  logic        busy_a, done_a, pass_a, fv_a;
  logic        busy_b, done_b, pass_b, fv_b;
  logic [9:0]  err_a;
  logic [3:0]  err_b;
  logic [8:0]  fvec_a, fvec_b;
  logic [2:0]  fy_a, fy_b;

  int checks = 0;
  int failures = 0;

  // fault_mode: 0 ideal, 1 gate2 stuck-at-0, 2 gate1 stuck-at-1, 3 random flips
  int         fault_mode = 0;
  logic [2:0] flip_mask [512];

  always #5 clk = ~clk;

  and3_triple_tester #(.SETTLE_CYCLES(2), .ERR_CNT_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_abort(in_abort),
    .in_y(y_a), .out_drive(drive_a), .out_busy(busy_a), .out_done(done_a),
    .out_pass(pass_a), .out_err_cnt(err_a), .out_fail_valid(fv_a),
    .out_fail_vec(fvec_a), .out_fail_y(fy_a)
  );

  and3_triple_tester #(.SETTLE_CYCLES(2), .ERR_CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_abort(in_abort),
    .in_y(y_b), .out_drive(drive_b), .out_busy(busy_b), .out_done(done_b),
    .out_pass(pass_b), .out_err_cnt(err_b), .out_fail_valid(fv_b),
    .out_fail_vec(fvec_b), .out_fail_y(fy_b)
  );

  function automatic logic [2:0] ideal_y(input logic [8:0] v);
    return {&v[8:6], &v[5:3], &v[2:0]};
  endfunction

  function automatic logic [2:0] device_y(input int mode, input logic [8:0] v);
    logic [2:0] y;
    y = ideal_y(v);
    case (mode)
      1: y = y & 3'b101;
      2: y = y | 3'b001;
      3: y = y ^ flip_mask[v];
      default: ;
    endcase
    return y;
  endfunction

  always_comb y_a = device_y(fault_mode, drive_a);
  always_comb y_b = device_y(fault_mode, drive_b);

  task automatic model_run(output int errs, output logic fv, output logic [8:0] fvec,
                           output logic [2:0] fy);
    logic [2:0] y;
    errs = 0; fv = 1'b0; fvec = '0; fy = '0;
    for (int v = 0; v < 512; v++) begin
      y = device_y(fault_mode, 9'(v));
      if (y != ideal_y(9'(v))) begin
        errs++;
        if (!fv) begin fv = 1'b1; fvec = 9'(v); fy = y; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    in_start = 1'b1; tick(); in_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({drive_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a, fy_a} !== '0 ||
        {drive_b, busy_b, done_b, pass_b, err_b, fv_b, fvec_b, fy_b} !== '0) begin
      failures++;
      $display("FAIL %s: outputs not zero, drive=%h busy=%b done=%b err=%0d fv=%b fvec=%h fy=%b (required all 0)",
               tag, drive_a, busy_a, done_a, err_a, fv_a, fvec_a, fy_a);
    end
  endtask

  // Full run from a start pulse; optionally sprinkles extra start pulses mid-run.
  task automatic run_and_check(input string tag, input bit extra_starts);
    int n, errs, errs4;
    logic fv;
    logic [8:0] fvec;
    logic [2:0] fy;
    model_run(errs, fv, fvec, fy);
    errs4 = (errs > 15) ? 15 : errs;
    pulse_start();
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || drive_a !== 9'h000) begin
      failures++;
      $display("FAIL %s_start: busy=%b done=%b drive=%h (required 1 0 000)", tag, busy_a, done_a, drive_a);
    end
    n = 0;
    while (done_a !== 1'b1 && n < RUN_CYCLES + 50) begin
      if (extra_starts && $urandom_range(0, 99) == 0) in_start = 1'b1;
      tick();
      in_start = 1'b0;
      n++;
    end
    checks++;
    if (n != RUN_CYCLES) begin
      failures++;
      $display("FAIL %s_len: run took %0d cycles (required %0d)", tag, n, RUN_CYCLES);
    end
    checks++;
    if (busy_a !== 1'b0 || pass_a !== (errs == 0) || drive_a !== 9'h1FF) begin
      failures++;
      $display("FAIL %s_end: busy=%b pass=%b drive=%h (required 0 %b 1ff)", tag, busy_a, pass_a, drive_a, errs == 0);
    end
    checks++;
    if (err_a !== 10'(errs) || fv_a !== fv) begin
      failures++;
      $display("FAIL %s_err: err=%0d fv=%b (required %0d %b)", tag, err_a, fv_a, errs, fv);
    end
    checks++;
    if (fv && (fvec_a !== fvec || fy_a !== fy)) begin
      failures++;
      $display("FAIL %s_first: fvec=%h fy=%b (required %h %b)", tag, fvec_a, fy_a, fvec, fy);
    end
    checks++;
    if (err_b !== 4'(errs4) || pass_b !== (errs == 0) || done_b !== 1'b1) begin
      failures++;
      $display("FAIL %s_err4: err=%0d pass=%b done=%b (required %0d %b 1)", tag, err_b, pass_b, done_b, errs4, errs == 0);
    end
  endtask

  task automatic wait_vector(input logic [8:0] v, input string tag);
    int n = 0;
    while (drive_a !== v && n < RUN_CYCLES) begin tick(); n++; end
    checks++;
    if (drive_a !== v) begin
      failures++;
      $display("FAIL %s_wait: drive=%h (required %h)", tag, drive_a, v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1; tick();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_ideal();
    fault_mode = 0; run_and_check("ideal", 1'b0);
  endtask

  task automatic test_gate2_stuck0();
    fault_mode = 1; run_and_check("g2_sa0", 1'b0);
    checks++;
    if (err_a !== 10'd64 || fvec_a !== 9'h038 || fy_a !== 3'b000) begin
      failures++;
      $display("FAIL g2_sa0_fixed: err=%0d fvec=%h fy=%b (required 64 038 000)", err_a, fvec_a, fy_a);
    end
  endtask

  task automatic test_gate1_stuck1();
    fault_mode = 2; run_and_check("g1_sa1", 1'b0);
    checks++;
    if (err_a !== 10'd448 || fvec_a !== 9'h000 || fy_a !== 3'b001 || err_b !== 4'd15) begin
      failures++;
      $display("FAIL g1_sa1_fixed: err=%0d fvec=%h fy=%b err4=%0d (required 448 000 001 15)",
               err_a, fvec_a, fy_a, err_b);
    end
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 512; v++)
        flip_mask[v] = ($urandom_range(0, 40 * r + 3) == 0) ? 3'($urandom) : 3'b000;
      fault_mode = 3;
      run_and_check($sformatf("rand%0d", r), 1'b0);
    end
  endtask

  task automatic test_abort();
    fault_mode = 2;
    pulse_start();
    wait_vector(9'd100, "abort");
    in_abort = 1'b1; tick(); in_abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || drive_a !== 9'h000 || fv_a !== 1'b1 || fvec_a !== 9'h000) begin
      failures++;
      $display("FAIL abort: busy=%b done=%b drive=%h fv=%b fvec=%h (required 0 0 000 1 000)",
               busy_a, done_a, drive_a, fv_a, fvec_a);
    end
    in_abort = 1'b1; tick(); in_abort = 1'b0; tick();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || fv_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_idle: busy=%b done=%b fv=%b (required 0 0 1)", busy_a, done_a, fv_a);
    end
    fault_mode = 0;
    run_and_check("after_abort", 1'b0);
    in_abort = 1'b1; tick(); in_abort = 1'b0;
    checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || drive_a !== 9'h1FF) begin
      failures++;
      $display("FAIL abort_done: done=%b pass=%b drive=%h (required 1 1 1ff)", done_a, pass_a, drive_a);
    end
  endtask

  task automatic test_back_to_back();
    fault_mode = 1;
    run_and_check("extra_starts", 1'b1);
    pulse_start();
    repeat ($urandom_range(5, 400)) tick();
    in_start = 1'b1; in_abort = 1'b1; tick();
    in_start = 1'b0; in_abort = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || drive_a !== 9'h000) begin
      failures++;
      $display("FAIL start_abort: busy=%b done=%b drive=%h (required 0 0 000)", busy_a, done_a, drive_a);
    end
  endtask

  task automatic test_reset_mid();
    for (int v = 0; v < 512; v++) flip_mask[v] = 3'($urandom);
    fault_mode = 3;
    pulse_start();
    wait_vector(9'd300, "rst_mid");
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_all_zero("rst_mid");
    fault_mode = 0;
    run_and_check("after_rst", 1'b0);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_gate2_stuck0();
    test_gate1_stuck1();
    test_random_faults();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
